// File: rtl/mem_access_unit_pkg.sv
// Shared types for the load/store sequencer.
//   mem_size_t      access size decoded from funct3[1:0]
//   load_funct3_t   RISC-V load funct3 encodings (RV64 adds LD, LWU)
//   store_funct3_t  RISC-V store funct3 encodings (RV64 adds SD)
//   mau_state_t     sequencer state
//   funct3_legal()  funct3 legality for a given access direction and XLEN
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'b00,
    SIZE_HALF  = 2'b01,
    SIZE_WORD  = 2'b10,
    SIZE_DWORD = 2'b11
  } mem_size_t;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110
  } load_funct3_t;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010,
    F3_SD = 3'b011
  } store_funct3_t;

  typedef enum logic [1:0] {
    MAU_IDLE,
    MAU_ACCESS,
    MAU_DONE
  } mau_state_t;

  function automatic logic funct3_legal(input logic st, input logic [2:0] f3,
                                        input logic rv64);
    logic ok;
    ok = 1'b0;
    if (st) begin
      case (f3)
        F3_SB, F3_SH, F3_SW: ok = 1'b1;
        F3_SD:               ok = rv64;
        default:             ok = 1'b0;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
        F3_LD, F3_LWU:                       ok = rv64;
        default:                             ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Memory-side request/response bus of the load/store sequencer.
//   mem_read/mem_write   access strobes, held until mem_resp
//   mem_addr             XLEN/8-aligned address
//   mem_byte_enable      byte lane enables
//   mem_wdata            lane-shifted store data
//   mem_resp             completion from memory
//   mem_rdata            aligned read data from memory
// master = sequencer side, slave = memory side.
interface mem_access_unit_if #(
  parameter int XLEN = 32
);
  logic                mem_read;
  logic                mem_write;
  logic [XLEN-1:0]     mem_addr;
  logic [XLEN/8-1:0]   mem_byte_enable;
  logic [XLEN-1:0]     mem_wdata;
  logic                mem_resp;
  logic [XLEN-1:0]     mem_rdata;

  modport master (
    output mem_read, mem_write, mem_addr, mem_byte_enable, mem_wdata,
    input  mem_resp, mem_rdata
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_byte_enable, mem_wdata,
    output mem_resp, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit_align.sv
// Combinational load/store lane decode.
//   is_store, funct3  access direction and RISC-V funct3
//   off               byte offset within the XLEN/8-byte word
//   wdata             right-aligned store data
//   rdata             aligned memory read data
//   legal             funct3 legal for XLEN and offset naturally aligned
//   byte_en           size mask shifted to the offset lane
//   wdata_sh          store data shifted to the offset lane
//   rdata_ext         selected load bytes, sign/zero-extended to XLEN
module mem_align
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                       is_store,
  input  logic [2:0]                 funct3,
  input  logic [$clog2(XLEN/8)-1:0]  off,
  input  logic [XLEN-1:0]            wdata,
  input  logic [XLEN-1:0]            rdata,
  output logic                       legal,
  output logic [XLEN/8-1:0]          byte_en,
  output logic [XLEN-1:0]            wdata_sh,
  output logic [XLEN-1:0]            rdata_ext
);
  localparam int NB = XLEN / 8;

  mem_size_t       size;
  logic            aligned;
  logic [NB-1:0]   size_mask;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] top_aligned;
  int unsigned     ext_sh;

  always_comb begin
    size      = mem_size_t'(funct3[1:0]);
    aligned   = 1'b1;
    size_mask = '0;
    ext_sh    = 0;
    case (size)
      SIZE_BYTE: begin
        size_mask[0] = 1'b1;
        ext_sh       = XLEN - 8;
      end
      SIZE_HALF: begin
        aligned        = ~off[0];
        size_mask[1:0] = '1;
        ext_sh         = XLEN - 16;
      end
      SIZE_WORD: begin
        aligned        = (off[1:0] == '0);
        size_mask[3:0] = '1;
        ext_sh         = XLEN - 32;
      end
      SIZE_DWORD: begin
        // Only legal when XLEN=64, where the full word is the access.
        aligned   = (off == '0);
        size_mask = '1;
        ext_sh    = 0;
      end
    endcase

    legal    = funct3_legal(is_store, funct3, XLEN == 64) & aligned;
    byte_en  = size_mask << off;
    wdata_sh = wdata << {off, 3'b000};

    // Move the selected bytes to the top, then shift back down arithmetically
    // or logically: truncation and extension in one step.
    shifted     = rdata >> {off, 3'b000};
    top_aligned = shifted << ext_sh;
    if (!funct3[2]) rdata_ext = $signed(top_aligned) >>> ext_sh;
    else            rdata_ext = top_aligned >> ext_sh;
  end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer: accepts one request while idle, runs the memory
// handshake with optional timeout, and reports a one-cycle done pulse.
//   clk, rst           clock; asynchronous active-low reset
//   start, is_store, funct3, addr, wdata   request (latched on accept)
//   mem                memory bus (master side)
//   busy               high from accept until the done cycle inclusive
//   done               one-cycle completion pulse
//   rdata              extended load result (valid with done)
//   rmask, wmask       RVFI lane masks for successful loads/stores
//   trap               illegal funct3 or misaligned (valid with done)
//   timeout_err        no mem_resp within TIMEOUT cycles (valid with done)
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_store,
  input  logic [2:0]           funct3,
  input  logic [XLEN-1:0]      addr,
  input  logic [XLEN-1:0]      wdata,
  mem_access_unit_if.master    mem,
  output logic                 busy,
  output logic                 done,
  output logic [XLEN-1:0]      rdata,
  output logic [XLEN/8-1:0]    rmask,
  output logic [XLEN/8-1:0]    wmask,
  output logic                 trap,
  output logic                 timeout_err
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = $clog2(TIMEOUT + 2);

  mau_state_t      state_q, state_d;
  logic            is_store_q, is_store_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [OFFW-1:0] off_q, off_d;
  logic            mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [NB-1:0]   be_q, be_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [NB-1:0]   rmask_q, rmask_d;
  logic [NB-1:0]   wmask_q, wmask_d;
  logic            trap_q, trap_d;
  logic            tout_q, tout_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // The single decoder sees the live request while idle (to build the
  // registered strobe/lane state) and the latched request afterwards (to
  // extract load data on mem_resp).
  logic            idle;
  logic            al_store;
  logic [2:0]      al_f3;
  logic [OFFW-1:0] al_off;
  logic            al_legal;
  logic [NB-1:0]   al_be;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_rdata;

  always_comb begin
    idle     = (state_q == MAU_IDLE);
    al_store = idle ? is_store           : is_store_q;
    al_f3    = idle ? funct3             : funct3_q;
    al_off   = idle ? addr[OFFW-1:0]     : off_q;
  end

  mem_align #(.XLEN(XLEN)) u_align (
    .is_store  (al_store),
    .funct3    (al_f3),
    .off       (al_off),
    .wdata     (wdata),
    .rdata     (mem.mem_rdata),
    .legal     (al_legal),
    .byte_en   (al_be),
    .wdata_sh  (al_wdata),
    .rdata_ext (al_rdata)
  );

  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    be_d        = be_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    rmask_d     = rmask_q;
    wmask_d     = wmask_q;
    trap_d      = trap_q;
    tout_d      = tout_q;
    cnt_d       = cnt_q;

    case (state_q)
      MAU_IDLE: begin
        if (start) begin
          is_store_d = is_store;
          funct3_d   = funct3;
          off_d      = addr[OFFW-1:0];
          cnt_d      = '0;
          if (!al_legal) begin
            trap_d  = 1'b1;
            state_d = MAU_DONE;
          end else begin
            mem_addr_d  = {addr[XLEN-1:OFFW], {OFFW{1'b0}}};
            be_d        = al_be;
            mem_wdata_d = al_wdata;
            mem_read_d  = ~is_store;
            mem_write_d = is_store;
            state_d     = MAU_ACCESS;
          end
        end
      end

      MAU_ACCESS: begin
        // cnt_q counts completed wait cycles; a response in the cycle the
        // count reaches TIMEOUT is still taken as success.
        if (mem.mem_resp) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          rdata_d     = al_rdata;
          rmask_d     = is_store_q ? '0 : be_q;
          wmask_d     = is_store_q ? be_q : '0;
          state_d     = MAU_DONE;
        end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT))) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          tout_d      = 1'b1;
          state_d     = MAU_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      MAU_DONE: begin
        rmask_d = '0;
        wmask_d = '0;
        trap_d  = 1'b0;
        tout_d  = 1'b0;
        state_d = MAU_IDLE;
      end

      default: state_d = MAU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= MAU_IDLE;
      is_store_q  <= 1'b0;
      funct3_q    <= '0;
      off_q       <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      be_q        <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      rmask_q     <= '0;
      wmask_q     <= '0;
      trap_q      <= 1'b0;
      tout_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      be_q        <= be_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      rmask_q     <= rmask_d;
      wmask_q     <= wmask_d;
      trap_q      <= trap_d;
      tout_q      <= tout_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mem.mem_read        = mem_read_q;
  assign mem.mem_write       = mem_write_q;
  assign mem.mem_addr        = mem_addr_q;
  assign mem.mem_byte_enable = be_q;
  assign mem.mem_wdata       = mem_wdata_q;

  assign busy        = (state_q != MAU_IDLE);
  assign done        = (state_q == MAU_DONE);
  assign rdata       = rdata_q;
  assign rmask       = rmask_q;
  assign wmask       = wmask_q;
  assign trap        = trap_q;
  assign timeout_err = tout_q;
endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  localparam int TO32 = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start32, start64, is_store, resp32, resp64;
  logic [2:0]  funct3;
  logic [63:0] addr, wdata, mrdata;

  mem_access_unit_if #(.XLEN(32)) m32 ();
  mem_access_unit_if #(.XLEN(64)) m64 ();
  assign m32.mem_resp  = resp32;
  assign m32.mem_rdata = mrdata[31:0];
  assign m64.mem_resp  = resp64;
  assign m64.mem_rdata = mrdata;

  logic        busy32, done32, trap32, tout32, busy64, done64, trap64, tout64;
  logic [31:0] rdata32;
  logic [63:0] rdata64;
  logic [3:0]  rmask32, wmask32;
  logic [7:0]  rmask64, wmask64;

  mem_access_unit #(.XLEN(32), .TIMEOUT(TO32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .is_store(is_store), .funct3(funct3),
    .addr(addr[31:0]), .wdata(wdata[31:0]), .mem(m32), .busy(busy32), .done(done32),
    .rdata(rdata32), .rmask(rmask32), .wmask(wmask32), .trap(trap32), .timeout_err(tout32));

  mem_access_unit #(.XLEN(64), .TIMEOUT(0)) dut64 (
    .clk(clk), .rst(rst), .start(start64), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .mem(m64), .busy(busy64), .done(done64),
    .rdata(rdata64), .rmask(rmask64), .wmask(wmask64), .trap(trap64), .timeout_err(tout64));

  bit          sel64;
  logic        o_read, o_write, o_busy, o_done, o_trap, o_tout;
  logic [63:0] o_addr, o_wdata, o_rdata;
  logic [7:0]  o_be, o_rmask, o_wmask;

  always_comb begin
    if (sel64) begin
      o_read = m64.mem_read; o_write = m64.mem_write; o_busy = busy64; o_done = done64;
      o_trap = trap64; o_tout = tout64; o_addr = m64.mem_addr; o_wdata = m64.mem_wdata;
      o_rdata = rdata64; o_be = m64.mem_byte_enable; o_rmask = rmask64; o_wmask = wmask64;
    end else begin
      o_read = m32.mem_read; o_write = m32.mem_write; o_busy = busy32; o_done = done32;
      o_trap = trap32; o_tout = tout32; o_addr = {32'b0, m32.mem_addr};
      o_wdata = {32'b0, m32.mem_wdata}; o_rdata = {32'b0, rdata32};
      o_be = {4'b0, m32.mem_byte_enable}; o_rmask = {4'b0, rmask32}; o_wmask = {4'b0, wmask32};
    end
  end

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    int          done_cyc;
    int          strobe_cyc;
    bit          rd_seen;
    bit          wr_seen;
    bit          stable;
    bit          busy_ok;
    bit          tail_ok;
    logic        trap;
    logic        tout;
    logic [7:0]  be;
    logic [7:0]  rmask;
    logic [7:0]  wmask;
    logic [63:0] maddr;
    logic [63:0] mwdata;
    logic [63:0] rdata;
  } obs_t;

  task automatic set_resp(input logic v);
    if (sel64) resp64 = v; else resp32 = v;
  endtask

  // Drive one request (cycle 0 = start cycle) and record what the DUT does.
  task automatic run_txn(input bit is64, input bit st, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] wd,
                         input logic [63:0] rd, input int waits, output obs_t o);
    o = '0;
    o.done_cyc = -1;
    o.stable   = 1'b1;
    o.busy_ok  = 1'b1;
    o.tail_ok  = 1'b1;
    sel64 = is64;
    @(negedge clk);
    is_store = st; funct3 = f3; addr = a; wdata = wd; mrdata = rd;
    if (is64) start64 = 1'b1; else start32 = 1'b1;
    set_resp(1'($urandom_range(0, 1)));  // stray response while idle
    for (int c = 1; c < 60; c++) begin
      @(negedge clk);
      start32 = 1'b0; start64 = 1'b0;
      if (c == 1) begin  // request inputs must already be latched
        is_store = 1'($urandom_range(0, 1)); funct3 = 3'($urandom_range(0, 7));
        addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
      end
      if (o_done) begin
        o.done_cyc = c; o.trap = o_trap; o.tout = o_tout; o.rdata = o_rdata;
        o.rmask = o_rmask; o.wmask = o_wmask;
        if (o_read || o_write || !o_busy) o.tail_ok = 1'b0;
        break;
      end
      if (o_read || o_write) begin
        if (o.strobe_cyc == 0) begin
          o.maddr = o_addr; o.be = o_be; o.mwdata = o_wdata;
        end else if (o.maddr !== o_addr || o.be !== o_be || o.mwdata !== o_wdata) begin
          o.stable = 1'b0;
        end
        o.strobe_cyc++;
        o.rd_seen |= o_read; o.wr_seen |= o_write;
        if (!o_busy) o.busy_ok = 1'b0;
      end
      set_resp(c == 1 + waits);
    end
    set_resp(1'($urandom_range(0, 1)));  // stray response in the done cycle
    @(negedge clk);
    set_resp(1'b0);
    if (o_done || o_busy || o_read || o_write) o.tail_ok = 1'b0;
  endtask

  // Reference: plain arithmetic over bytes and offsets.
  function automatic obs_t model(input bit is64, input bit st, input logic [2:0] f3,
                                 input logic [63:0] a, input logic [63:0] wd,
                                 input logic [63:0] rd, input int waits);
    obs_t        e;
    int          nb, off, sz;
    bit          legal;
    logic [63:0] wm, v, m;
    e = '0;
    e.stable = 1'b1; e.busy_ok = 1'b1; e.tail_ok = 1'b1;
    nb  = is64 ? 8 : 4;
    wm  = is64 ? '1 : 64'h0000_0000_FFFF_FFFF;
    off = int'(a % 64'(nb));
    sz  = 1 << f3[1:0];
    if (st) legal = (f3 <= 3'd2) || (is64 && f3 == 3'd3);
    else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (is64 && (f3 == 3'd3 || f3 == 3'd6));
    if (off % sz != 0) legal = 1'b0;
    if (!legal) begin
      e.trap = 1'b1; e.done_cyc = 1;
      return e;
    end
    e.be     = 8'(((1 << sz) - 1) << off);
    e.maddr  = (a & wm) - 64'(off);
    e.mwdata = ((wd & wm) << (8 * off)) & wm;
    e.rd_seen = !st; e.wr_seen = st;
    if (!is64 && waits > TO32) begin
      e.tout = 1'b1; e.done_cyc = TO32 + 2; e.strobe_cyc = TO32 + 1;
      return e;
    end
    e.done_cyc = waits + 2; e.strobe_cyc = waits + 1;
    if (st) e.wmask = e.be;
    else begin
      e.rmask = e.be;
      v = (rd & wm) >> (8 * off);
      if (sz < 8) begin
        m = (64'd1 << (8 * sz)) - 1;
        v = v & m;
        if (!f3[2] && v[8 * sz - 1]) v = v | ~m;
      end
      e.rdata = v & wm;
    end
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    #1;
    total++;
    if ({busy32, done32, trap32, tout32, m32.mem_read, m32.mem_write, busy64, done64,
         trap64, tout64, m64.mem_read, m64.mem_write} !== '0) begin
      bad++; $display("FAIL reset_ctrl got nonzero control outputs");
    end
    total++;
    if ({m32.mem_addr, m32.mem_byte_enable, m32.mem_wdata, rdata32, rmask32, wmask32,
         m64.mem_addr, m64.mem_byte_enable, m64.mem_wdata, rdata64, rmask64, wmask64} !== '0) begin
      bad++; $display("FAIL reset_data got nonzero data outputs");
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (busy32 !== 1'b0 || busy64 !== 1'b0) begin
      bad++; $display("FAIL reset_idle busy32=%b busy64=%b want 0", busy32, busy64);
    end
  endtask

  task automatic test_lh();
    obs_t o;
    run_txn(0, 0, 3'b001, 64'h102, 64'h0, 64'h8001_1234, 0, o);
    total++;
    if (o.be !== 8'hC || o.maddr !== 64'h100 || !o.rd_seen || o.wr_seen) begin
      bad++; $display("FAIL lh_bus be=%h addr=%h rd=%b wr=%b want C 100 1 0", o.be, o.maddr, o.rd_seen, o.wr_seen);
    end
    total++;
    if (o.rdata !== 64'hFFFF_8001 || o.rmask !== 8'hC || o.wmask !== 8'h0) begin
      bad++; $display("FAIL lh_data rdata=%h rmask=%h wmask=%h want FFFF8001 C 0", o.rdata, o.rmask, o.wmask);
    end
    total++;
    if (o.done_cyc != 2 || o.trap !== 1'b0 || !o.tail_ok) begin
      bad++; $display("FAIL lh_timing done_cyc=%0d trap=%b tail=%b want 2 0 1", o.done_cyc, o.trap, o.tail_ok);
    end
  endtask

  task automatic test_sb_waits();
    obs_t o;
    run_txn(0, 1, 3'b000, 64'h203, 64'hAB, 64'h0, 3, o);
    total++;
    if (o.maddr !== 64'h200 || o.be !== 8'h8 || o.mwdata !== 64'hAB00_0000 || !o.stable) begin
      bad++; $display("FAIL sb_bus addr=%h be=%h wdata=%h stable=%b want 200 8 AB000000 1", o.maddr, o.be, o.mwdata, o.stable);
    end
    total++;
    if (o.wmask !== 8'h8 || o.rmask !== 8'h0 || o.done_cyc != 5 || o.strobe_cyc != 4 || !o.wr_seen) begin
      bad++; $display("FAIL sb_done wmask=%h rmask=%h done_cyc=%0d strobes=%0d want 8 0 5 4", o.wmask, o.rmask, o.done_cyc, o.strobe_cyc);
    end
  endtask

  task automatic test_trap();
    obs_t o;
    run_txn(0, 0, 3'b010, 64'h101, 64'h0, 64'hFFFF_FFFF, 0, o);
    total++;
    if (o.trap !== 1'b1 || o.done_cyc != 1 || o.strobe_cyc != 0 || o.rmask !== 8'h0 || o.wmask !== 8'h0) begin
      bad++; $display("FAIL trap_lw trap=%b done_cyc=%0d strobes=%0d masks=%h/%h want 1 1 0 0/0", o.trap, o.done_cyc, o.strobe_cyc, o.rmask, o.wmask);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_txn(0, 0, 3'b010, 64'h100, 64'h0, 64'h1234_5678, 1000, o);
    total++;
    if (o.tout !== 1'b1 || o.done_cyc != TO32 + 2 || o.strobe_cyc != TO32 + 1 || o.rmask !== 8'h0 || !o.tail_ok) begin
      bad++; $display("FAIL timeout tout=%b done_cyc=%0d strobes=%0d rmask=%h want 1 %0d %0d 0", o.tout, o.done_cyc, o.strobe_cyc, o.rmask, TO32 + 2, TO32 + 1);
    end
    run_txn(0, 0, 3'b010, 64'h100, 64'h0, 64'h1234_5678, TO32, o);
    total++;
    if (o.tout !== 1'b0 || o.done_cyc != TO32 + 2 || o.rdata !== 64'h1234_5678 || o.rmask !== 8'hF) begin
      bad++; $display("FAIL resp_at_expiry tout=%b done_cyc=%0d rdata=%h rmask=%h want 0 %0d 12345678 F", o.tout, o.done_cyc, o.rdata, o.rmask, TO32 + 2);
    end
  endtask

  task automatic test_lwu64();
    obs_t o;
    run_txn(1, 0, 3'b110, 64'h1004, 64'h0, 64'hF000_0000_0000_0000, 1, o);
    total++;
    if (o.be !== 8'hF0 || o.rdata !== 64'h0000_0000_F000_0000 || o.rmask !== 8'hF0 || o.maddr !== 64'h1000 || o.done_cyc != 3) begin
      bad++; $display("FAIL lwu64 be=%h rdata=%h rmask=%h addr=%h done_cyc=%0d want F0 F0000000 F0 1000 3", o.be, o.rdata, o.rmask, o.maddr, o.done_cyc);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o, e;
    bit   seen_done;
    sel64 = 1'b0;
    @(negedge clk);
    is_store = 1'b0; funct3 = 3'b010; addr = 64'h300; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    total++;
    if (o_read !== 1'b1) begin
      bad++; $display("FAIL rstmid_pre mem_read=%b want 1", o_read);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if (o_read !== 1'b0 || o_busy !== 1'b0) begin
      bad++; $display("FAIL rstmid_drop mem_read=%b busy=%b want 0 0", o_read, o_busy);
    end
    @(negedge clk);
    rst = 1'b1;
    seen_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen_done |= o_done;
    end
    total++;
    if (seen_done) begin
      bad++; $display("FAIL rstmid_nodone done pulse seen=%b want 0", seen_done);
    end
    run_txn(0, 0, 3'b100, 64'h301, 64'h0, 64'h0000_9A00, 1, o);
    e = model(0, 0, 3'b100, 64'h301, 64'h0, 64'h0000_9A00, 1);
    total++;
    if (o !== e) begin
      bad++; $display("FAIL rstmid_next got=%h want=%h", o, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] seq;
    sel64 = 1'b0;
    @(negedge clk);
    is_store = 1'b0; funct3 = 3'b001; addr = 64'h101; start32 = 1'b1;  // trapping lh
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      seq[c] = o_done;
    end
    start32 = 1'b0;
    total++;
    if (seq !== 3'b101) begin
      bad++; $display("FAIL start_in_done done_seq=%b want 101", seq);
    end
    repeat (2) @(negedge clk);
    total++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      bad++; $display("FAIL b2b_settle busy=%b done=%b want 0 0", o_busy, o_done);
    end
  endtask

  task automatic test_random(input bit is64, input int n);
    obs_t        o, e;
    bit          st;
    logic [2:0]  f3;
    logic [63:0] a, wd, rd;
    int          waits;
    for (int i = 0; i < n; i++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << f3[1:0]) - 1);
      wd = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      waits = $urandom_range(0, 6);
      e = model(is64, st, f3, a, wd, rd, waits);
      run_txn(is64, st, f3, a, wd, rd, waits, o);
      if (st || e.trap || e.tout) o.rdata = '0;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL rand%0d_%0d st=%b f3=%0d a=%h waits=%0d got=%h want=%h", is64 ? 64 : 32, i, st, f3, a, waits, o, e);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sel64 = 1'b0; start32 = 1'b0; start64 = 1'b0; is_store = 1'b0; funct3 = '0;
    addr = '0; wdata = '0; mrdata = '0; resp32 = 1'b0; resp64 = 1'b0;
    test_reset();
    test_lh();
    test_sb_waits();
    test_trap();
    test_timeout();
    test_lwu64();
    test_reset_mid();
    test_back_to_back();
    test_random(0, 150);
    test_random(1, 150);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
